// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the PC, issues one instruction-memory read at a
// time, holds the returned word for decode and steers the next PC on retirement.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_src,
  input  logic [31:0] alu_out,
  input  logic [31:0] imm,
  input  logic        hlt,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        misalign_err
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    HALT  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [XLEN-1:0]   pc_d, instr_d, next_pc;
  logic              req_d, valid_d, halted_d, err_d;

  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);

  // Next-PC candidate; JALR target has bit 0 cleared.
  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_src)
      2'b01:   next_pc = alu_out & ~XLEN'(1);
      2'b10:   next_pc = pc + imm;
      default: next_pc = pc_plus4;
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      imem_req     <= 1'b0;
      halted       <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      instr        <= instr_d;
      instr_valid  <= valid_d;
      imem_req     <= req_d;
      halted       <= halted_d;
      misalign_err <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    instr_d  = instr;
    valid_d  = instr_valid;
    req_d    = imem_req;
    halted_d = halted;
    err_d    = misalign_err;
    unique case (state)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (advance) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (hlt) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            req_d   = 1'b1;
            state_d = FETCH;
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end
      HALT, ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table covering the
// main fetch/branch paths, plus hand-written misalign, halt and reset sequences.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src;
  logic [31:0] alu_out, imm;
  logic        hlt, advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4;
  logic        halted, misalign_err;

  int checks = 0;
  int failures = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_src(pc_src), .alu_out(alu_out), .imm(imm),
    .hlt(hlt), .advance(advance), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        adv;
    logic        hlt;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] imm;
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_halted;
    logic        e_err;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic e_valid,
                           input logic [31:0] e_instr, input logic [31:0] e_pc,
                           input logic e_halted, input logic e_err);
    logic [31:0] e_p4;
    e_p4 = e_pc + 32'd4;
    chk({tag, " imem_req"}, 32'(imem_req), 32'(e_req));
    chk({tag, " instr_valid"}, 32'(instr_valid), 32'(e_valid));
    chk({tag, " instr"}, instr, e_instr);
    chk({tag, " pc"}, pc, e_pc);
    chk({tag, " imem_addr"}, imem_addr, e_pc);
    chk({tag, " pc_plus4"}, pc_plus4, e_p4);
    chk({tag, " halted"}, 32'(halted), 32'(e_halted));
    chk({tag, " misalign_err"}, 32'(misalign_err), 32'(e_err));
  endtask

  task automatic step(input logic ack, input logic [31:0] rdata, input logic adv,
                      input logic h, input logic [1:0] src, input logic [31:0] alu,
                      input logic [31:0] im);
    imem_ack   = ack;
    imem_rdata = rdata;
    advance    = adv;
    hlt        = h;
    pc_src     = src;
    alu_out    = alu;
    imm        = im;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    imem_ack = 1'b0; imem_rdata = '0; advance = 1'b0; hlt = 1'b0;
    pc_src = 2'b00; alu_out = '0; imm = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all({tag, " reset"}, 1'b0, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0; imem_rdata = '0; advance = 1'b0; hlt = 1'b0;
    pc_src = 2'b00; alu_out = '0; imm = '0;

    //           ack  rdata          adv  hlt  src    alu            imm            req  val  instr          pc             hlt  err
    vecs[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 1'b0, NOP,           32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 1'b0, NOP,           32'h0,        1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 1'b0, NOP,           32'h0,        1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h00500093, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 1'b1, 32'h00500093,  32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 2'b10, 32'h0,        32'h40,       1'b0, 1'b1, 32'h00500093,  32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 1'b1, 32'h00500093,  32'h0,        1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b10, 32'h0,        32'h100,      1'b1, 1'b0, NOP,           32'h100,      1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 2'b10, 32'h0,        32'h8,        1'b1, 1'b0, NOP,           32'h100,      1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 1'b1, 32'h11111111,  32'h100,      1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b10, 32'h0,        32'hFFFFFFF8, 1'b1, 1'b0, NOP,           32'h0F8,      1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h22222222, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 1'b1, 32'h22222222,  32'h0F8,      1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b01, 32'h00001001, 32'h0,        1'b1, 1'b0, NOP,           32'h1000,     1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'h33333333, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 1'b1, 32'h33333333,  32'h1000,     1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b11, 32'h7,        32'h40,       1'b1, 1'b0, NOP,           32'h1004,     1'b0, 1'b0};
    vecs[14] = '{1'b1, 32'h44444444, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 1'b1, 32'h44444444,  32'h1004,     1'b0, 1'b0};
    vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b10, 32'h0,        32'hFFFFEFF8, 1'b1, 1'b0, NOP,           32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 32'h55555555, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 1'b1, 32'h55555555,  32'hFFFFFFFC, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        1'b1, 1'b0, NOP,           32'h0,        1'b0, 1'b0};
    vecs[18] = '{1'b1, 32'h66666666, 1'b0, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 1'b1, 32'h66666666,  32'h0,        1'b0, 1'b0};
    vecs[19] = '{1'b0, 32'h0,        1'b1, 1'b0, 2'b10, 32'h0,        32'h2,        1'b0, 1'b0, NOP,           32'h0,        1'b0, 1'b1};
    vecs[20] = '{1'b1, 32'h77777777, 1'b1, 1'b0, 2'b00, 32'h0,        32'h0,        1'b0, 1'b0, NOP,           32'h0,        1'b0, 1'b1};

    do_reset("table");
    // The do_reset edge already moved IDLE->FETCH; vecs[0] expects that state.
    check_all("v0", vecs[0].e_req, vecs[0].e_valid, vecs[0].e_instr, vecs[0].e_pc,
              vecs[0].e_halted, vecs[0].e_err);
    for (int i = 1; i < 21; i++) begin
      step(vecs[i].ack, vecs[i].rdata, vecs[i].adv, vecs[i].hlt, vecs[i].src,
           vecs[i].alu, vecs[i].imm);
      check_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_valid, vecs[i].e_instr,
                vecs[i].e_pc, vecs[i].e_halted, vecs[i].e_err);
    end

    // JALR to an odd-halfword target: error, PC kept, no request.
    do_reset("jalr");
    step(1'b1, 32'h00000067, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    check_all("jalr hold", 1'b0, 1'b1, 32'h00000067, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 2'b01, 32'h00002003, 32'h0);
    check_all("jalr err", 1'b0, 1'b0, NOP, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(i[0], 32'hBAD0BAD0, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      check_all($sformatf("jalr stay%0d", i), 1'b0, 1'b0, NOP, 32'h0, 1'b0, 1'b1);
    end

    // Halt takes priority over pc_src and is terminal.
    do_reset("halt");
    step(1'b1, 32'h00000073, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    check_all("halt hold", 1'b0, 1'b1, 32'h00000073, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h0, 32'h8);
    check_all("halt enter", 1'b0, 1'b0, NOP, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(~i[0], 32'h12345678, i[0], i[1], 2'b10, 32'h3, 32'h4);
      check_all($sformatf("halt c%0d", i), 1'b0, 1'b0, NOP, 32'h0, 1'b1, 1'b0);
    end

    // Asynchronous reset mid-FETCH; a late ack must not load instr.
    do_reset("arst");
    check_all("arst fetch", 1'b1, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all("arst async", 1'b0, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    imem_ack = 1'b1;
    imem_rdata = 32'hBADBAD00;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("arst idle ack", 1'b1, 1'b0, NOP, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    check_all("arst fetch2", 1'b1, 1'b0, NOP, 32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
